// File: rtl/common_pkg.sv
// Shared scalar types used across the pipeline.
package common;
    typedef logic [31:0] u32;
    typedef logic [63:0] u64;
    typedef u64          addr_t;
endpackage

// File: rtl/pipes_pkg.sv
// Inter-stage payload types and fetch-stage local types.
package pipes;
    import common::*;

    // Address of the first fetch after reset.
    localparam addr_t PC_RESET = 64'h0000_0000_8000_0000;

    // Payload handed from fetch to decode.
    typedef struct packed {
        logic  valid;
        addr_t pc_now;
        u32    raw_instr;
    } data_fetch_t;

    // S_KILL waits out a stale bus response after a redirect.
    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_KILL = 2'd1,
        S_FULL = 2'd2
    } fetch_state_t;

    // One-entry skid buffer contents.
    typedef struct packed {
        logic  valid;
        addr_t pc;
        u32    instr;
    } fetch_entry_t;
endpackage

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, drives the instruction bus, and feeds decode one
// instruction per cycle. A one-entry skid buffer absorbs decode stalls, and a
// kill state swallows the wrong-path response that is in flight at a redirect.
module instr_fetch
    import common::*;
    import pipes::*;
#(
    parameter addr_t PC_RESET = pipes::PC_RESET
) (
    input  logic        clk,
    input  logic        reset,
    output logic        ireq_valid,
    output addr_t       ireq_addr,
    input  logic        iresp_data_ok,
    input  u32          iresp_data,
    input  logic        stall,
    input  logic        branch,
    input  addr_t       branch_target,
    output data_fetch_t data_f
);

    fetch_state_t state_q;
    addr_t        pc_q;
    addr_t        req_addr_q;
    data_fetch_t  out_q;
    fetch_entry_t buf_q;

    logic out_free;
    logic redirect;

    // OUT can take new data when empty or being consumed this cycle;
    // a branch seen under stall is ignored since decode re-presents it.
    always_comb begin
        out_free = !out_q.valid || !stall;
        redirect = branch && !stall;
    end

    // Bus request is live in every state except S_FULL; reset forces it low.
    always_comb begin
        ireq_valid = !reset && (state_q != S_FULL);
        ireq_addr  = req_addr_q;
        data_f     = out_q;
    end

    // Fetch FSM, PC, output register and skid buffer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_REQ;
            pc_q       <= PC_RESET;
            req_addr_q <= PC_RESET;
            out_q      <= '0;
            buf_q      <= '0;
        end else begin
            // A consumed OUT drops out unless refilled below.
            if (!stall) out_q.valid <= 1'b0;

            unique case (state_q)
                S_REQ: begin
                    if (iresp_data_ok) begin
                        if (redirect) begin
                            // Response belongs to the wrong path: discard it.
                            pc_q       <= branch_target;
                            req_addr_q <= branch_target;
                        end else begin
                            if (out_free) begin
                                out_q <= '{valid: 1'b1, pc_now: req_addr_q, raw_instr: iresp_data};
                            end else begin
                                buf_q   <= '{valid: 1'b1, pc: req_addr_q, instr: iresp_data};
                                state_q <= S_FULL;
                            end
                            pc_q       <= req_addr_q + 64'd4;
                            req_addr_q <= req_addr_q + 64'd4;
                        end
                    end else if (redirect) begin
                        // Keep the bus address stable until the stale reply lands.
                        pc_q    <= branch_target;
                        state_q <= S_KILL;
                    end
                end
                S_FULL: begin
                    if (redirect) begin
                        buf_q.valid <= 1'b0;
                        pc_q        <= branch_target;
                        req_addr_q  <= branch_target;
                        state_q     <= S_REQ;
                    end else if (!stall) begin
                        out_q   <= '{valid: buf_q.valid, pc_now: buf_q.pc, raw_instr: buf_q.instr};
                        buf_q.valid <= 1'b0;
                        state_q <= S_REQ;
                    end
                end
                S_KILL: begin
                    if (iresp_data_ok) begin
                        // Stale response dropped; a concurrent redirect still wins.
                        pc_q       <= redirect ? branch_target : pc_q;
                        req_addr_q <= redirect ? branch_target : pc_q;
                        state_q    <= S_REQ;
                    end else if (redirect) begin
                        pc_q <= branch_target;
                    end
                end
                default: state_q <= S_REQ;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: streaming, stall/skid, redirects, wrap, reset.
module tb_instr_fetch;
    import common::*;
    import pipes::*;

    localparam addr_t BASE = 64'h0000_0000_8000_0000;
    localparam addr_t WRAP = 64'hFFFF_FFFF_FFFF_FFFC;

    logic        clk = 1'b0;
    logic        reset;
    logic        ireq_valid, ireq_valid2;
    addr_t       ireq_addr, ireq_addr2;
    logic        iresp_data_ok;
    u32          iresp_data;
    logic        stall;
    logic        branch;
    addr_t       branch_target;
    data_fetch_t data_f, data_f2;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    instr_fetch dut (
        .clk(clk), .reset(reset),
        .ireq_valid(ireq_valid), .ireq_addr(ireq_addr),
        .iresp_data_ok(iresp_data_ok), .iresp_data(iresp_data),
        .stall(stall), .branch(branch), .branch_target(branch_target),
        .data_f(data_f)
    );

    instr_fetch #(.PC_RESET(WRAP)) dut_wrap (
        .clk(clk), .reset(reset),
        .ireq_valid(ireq_valid2), .ireq_addr(ireq_addr2),
        .iresp_data_ok(iresp_data_ok), .iresp_data(iresp_data),
        .stall(stall), .branch(branch), .branch_target(branch_target),
        .data_f(data_f2)
    );

    function automatic u32 word_of(addr_t a);
        return a[31:0] ^ 32'hA5A5_0000;
    endfunction

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        iresp_data_ok = 0; iresp_data = '0; stall = 0; branch = 0; branch_target = '0;
        reset = 1;
        tick();
        reset = 0;
        #1;
    endtask

    // Accept a response for the current address on the next edge.
    task automatic respond();
        iresp_data_ok = 1;
        iresp_data    = word_of(ireq_addr);
        tick();
        iresp_data_ok = 0;
    endtask

    task automatic test_reset();
        iresp_data_ok = 0; iresp_data = '0; stall = 0; branch = 0; branch_target = '0;
        reset = 1;
        #3;
        checks++;
        if (ireq_valid !== 1'b0) begin failures++; $display("FAIL reset_ireq_valid got=%b want=0", ireq_valid); end
        checks++;
        if (data_f.valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b want=0", data_f.valid); end
        checks++;
        if (ireq_addr !== BASE) begin failures++; $display("FAIL reset_addr got=%h want=%h", ireq_addr, BASE); end
        tick();
        reset = 0;
        #1;
        checks++;
        if (ireq_valid !== 1'b1) begin failures++; $display("FAIL post_reset_ireq_valid got=%b want=1", ireq_valid); end
    endtask

    task automatic test_stream();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            addr_t exp_pc;
            exp_pc = BASE + 64'(4 * i);
            respond();
            iresp_data_ok = 1;
            checks++;
            if (data_f.valid !== 1'b1 || data_f.pc_now !== exp_pc || data_f.raw_instr !== word_of(exp_pc)) begin
                failures++;
                $display("FAIL stream_%0d got=%b/%h/%h want=1/%h/%h", i, data_f.valid, data_f.pc_now, data_f.raw_instr, exp_pc, word_of(exp_pc));
            end
        end
        iresp_data_ok = 0;
    endtask

    task automatic test_stall_skid();
        do_reset();
        respond();
        respond();
        stall = 1;
        respond();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (data_f.valid !== 1'b1 || data_f.pc_now !== BASE + 64'h4 || ireq_valid !== 1'b0) begin
                failures++;
                $display("FAIL stall_hold_%0d got=%b/%h ireq_valid=%b want=1/%h ireq_valid=0", i, data_f.valid, data_f.pc_now, ireq_valid, BASE + 64'h4);
            end
            if (i < 2) tick();
        end
        stall = 0;
        tick();
        checks++;
        if (data_f.valid !== 1'b1 || data_f.pc_now !== BASE + 64'h8 || data_f.raw_instr !== word_of(BASE + 64'h8)) begin
            failures++;
            $display("FAIL skid_drain got=%b/%h/%h want=1/%h/%h", data_f.valid, data_f.pc_now, data_f.raw_instr, BASE + 64'h8, word_of(BASE + 64'h8));
        end
        checks++;
        if (ireq_valid !== 1'b1 || ireq_addr !== BASE + 64'hC) begin
            failures++;
            $display("FAIL resume_addr got=%b/%h want=1/%h", ireq_valid, ireq_addr, BASE + 64'hC);
        end
        respond();
        checks++;
        if (data_f.valid !== 1'b1 || data_f.pc_now !== BASE + 64'hC) begin
            failures++;
            $display("FAIL resume_out got=%b/%h want=1/%h", data_f.valid, data_f.pc_now, BASE + 64'hC);
        end
    endtask

    task automatic test_redirect_kill();
        do_reset();
        respond();
        respond();
        branch = 1; branch_target = BASE + 64'h100;
        tick();
        branch = 0;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (ireq_valid !== 1'b1 || ireq_addr !== BASE + 64'h8 || data_f.valid !== 1'b0) begin
                failures++;
                $display("FAIL kill_wait_%0d got=%b/%h out_valid=%b want=1/%h out_valid=0", i, ireq_valid, ireq_addr, data_f.valid, BASE + 64'h8);
            end
            if (i == 0) tick();
        end
        respond();
        checks++;
        if (data_f.valid !== 1'b0 || ireq_addr !== BASE + 64'h100) begin
            failures++;
            $display("FAIL kill_drop got=%b/%h want=0/%h", data_f.valid, ireq_addr, BASE + 64'h100);
        end
        respond();
        checks++;
        if (data_f.valid !== 1'b1 || data_f.pc_now !== BASE + 64'h100) begin
            failures++;
            $display("FAIL kill_target got=%b/%h want=1/%h", data_f.valid, data_f.pc_now, BASE + 64'h100);
        end
    endtask

    task automatic test_redirect_same_cycle();
        do_reset();
        respond();
        respond();
        branch = 1; branch_target = BASE + 64'h100;
        respond();
        branch = 0;
        checks++;
        if (data_f.valid !== 1'b0 || ireq_addr !== BASE + 64'h100 || ireq_valid !== 1'b1) begin
            failures++;
            $display("FAIL same_cycle_drop got=%b/%h/%b want=0/%h/1", data_f.valid, ireq_addr, ireq_valid, BASE + 64'h100);
        end
        respond();
        checks++;
        if (data_f.valid !== 1'b1 || data_f.pc_now !== BASE + 64'h100) begin
            failures++;
            $display("FAIL same_cycle_target got=%b/%h want=1/%h", data_f.valid, data_f.pc_now, BASE + 64'h100);
        end
    endtask

    task automatic test_branch_stall();
        do_reset();
        respond();
        respond();
        stall = 1; branch = 1; branch_target = BASE + 64'h200;
        tick();
        checks++;
        if (data_f.valid !== 1'b1 || data_f.pc_now !== BASE + 64'h4 || ireq_addr !== BASE + 64'h8 || ireq_valid !== 1'b1) begin
            failures++;
            $display("FAIL branch_under_stall got=%b/%h/%h/%b want=1/%h/%h/1", data_f.valid, data_f.pc_now, ireq_addr, ireq_valid, BASE + 64'h4, BASE + 64'h8);
        end
        stall = 0;
        tick();
        branch = 0;
        checks++;
        if (data_f.valid !== 1'b0 || ireq_addr !== BASE + 64'h8) begin
            failures++;
            $display("FAIL branch_after_stall got=%b/%h want=0/%h", data_f.valid, ireq_addr, BASE + 64'h8);
        end
        respond();
        checks++;
        if (ireq_addr !== BASE + 64'h200 || data_f.valid !== 1'b0) begin
            failures++;
            $display("FAIL branch_after_stall_target got=%h/%b want=%h/0", ireq_addr, data_f.valid, BASE + 64'h200);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        checks++;
        if (ireq_addr2 !== WRAP) begin failures++; $display("FAIL wrap_first got=%h want=%h", ireq_addr2, WRAP); end
        iresp_data_ok = 1; iresp_data = 32'h1234_5678;
        tick();
        iresp_data_ok = 0;
        checks++;
        if (ireq_addr2 !== 64'h0 || data_f2.valid !== 1'b1 || data_f2.pc_now !== WRAP) begin
            failures++;
            $display("FAIL wrap_second got=%h/%b/%h want=0/1/%h", ireq_addr2, data_f2.valid, data_f2.pc_now, WRAP);
        end
    endtask

    task automatic test_reset_in_kill();
        do_reset();
        respond();
        branch = 1; branch_target = BASE + 64'h300;
        tick();
        branch = 0;
        reset = 1;
        #2;
        checks++;
        if (ireq_valid !== 1'b0 || data_f.valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_kill_async got=%b/%b want=0/0", ireq_valid, data_f.valid);
        end
        reset = 0;
        #1;
        checks++;
        if (ireq_valid !== 1'b1 || ireq_addr !== BASE || data_f.valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_kill_restart got=%b/%h/%b want=1/%h/0", ireq_valid, ireq_addr, data_f.valid, BASE);
        end
        respond();
        checks++;
        if (data_f.valid !== 1'b1 || data_f.pc_now !== BASE) begin
            failures++;
            $display("FAIL reset_kill_first got=%b/%h want=1/%h", data_f.valid, data_f.pc_now, BASE);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall_skid();
        test_redirect_kill();
        test_redirect_same_cycle();
        test_branch_stall();
        test_wrap();
        test_reset_in_kill();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
